// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register carrying pc, instr,
// a delay-slot flag and a DATA_W-bit payload between two pipeline stages.
//
// Handshake: an item moves across an interface on a rising clock edge only
// when its valid and ready are both high in that cycle (in_valid & in_ready
// upstream, out_valid & out_ready downstream). Valid never waits on ready;
// nothing moves in a cycle where flush (or reset) is high.
//
// SKID=0 keeps one entry and in_ready is combinational from out_ready.
// SKID=1 adds a second (skid) entry so in_ready is a flop: while the main
// entry is stalled, one extra item parks in the skid entry, and the stage
// stops accepting only when both entries are occupied.
module pipe_stage_reg #(
    parameter int DATA_W  = 128,
    parameter int SKID    = 1,
    parameter int KEEP_PC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic              in_bd,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic              out_bd,
    output logic [DATA_W-1:0] out_data
);

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       instr;
        logic              bd;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Main entry drives the outputs; skid entry holds the one item that
    // arrived while the main entry was stalled.
    entry_t mainEntry;
    logic   mainValid;
    entry_t skidEntry;
    logic   skidValid;
    logic   readyQ;

    entry_t inEntry;
    logic   stageReady;
    logic   inXfer;
    logic   outXfer;

    assign inEntry = '{pc: in_pc, instr: in_instr, bd: in_bd, data: in_data};

    // With a skid entry the ready is the registered "skid empty"; without one
    // the stage can take an item whenever its single entry is empty or leaving.
    assign stageReady = (SKID != 0) ? readyQ : (~mainValid | out_ready);

    // Flush kills both transfers for the cycle.
    assign inXfer  = in_valid & stageReady & ~flush;
    assign outXfer = mainValid & out_ready & ~flush;

    // Entry storage and occupancy update; reset wins over flush, flush over transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mainEntry <= '0;
            mainValid <= 1'b0;
            skidEntry <= '0;
            skidValid <= 1'b0;
            readyQ    <= 1'b1;
        end else if (flush) begin
            // The bubble carries a nop and zero payload; pc/bd optionally
            // track the incoming item so CP0 still sees a sensible pc.
            mainValid       <= 1'b0;
            mainEntry.instr <= '0;
            mainEntry.data  <= '0;
            if (KEEP_PC != 0) begin
                if (in_valid) begin
                    mainEntry.pc <= in_pc;
                    mainEntry.bd <= in_bd;
                end
            end else begin
                mainEntry.pc <= '0;
                mainEntry.bd <= 1'b0;
            end
            skidEntry <= '0;
            skidValid <= 1'b0;
            readyQ    <= 1'b1;
        end else if (SKID != 0) begin
            if (outXfer && skidValid) begin
                // Drain: the parked item moves forward. readyQ is low here,
                // so no new item can arrive in the same cycle.
                mainEntry <= skidEntry;
                skidValid <= 1'b0;
                readyQ    <= 1'b1;
            end else if (inXfer && mainValid && !outXfer) begin
                // Main is stalled: park the new item and stop accepting.
                skidEntry <= inEntry;
                skidValid <= 1'b1;
                readyQ    <= 1'b0;
            end else if (inXfer) begin
                // Main is empty or emptying this cycle: load it directly.
                mainEntry <= inEntry;
                mainValid <= 1'b1;
            end else if (outXfer) begin
                mainValid <= 1'b0;
            end
        end else begin
            if (inXfer) begin
                mainEntry <= inEntry;
                mainValid <= 1'b1;
            end else if (outXfer) begin
                mainValid <= 1'b0;
            end
        end
    end

    assign in_ready  = stageReady;
    assign out_valid = mainValid;
    assign out_pc    = mainEntry.pc;
    assign out_instr = mainEntry.instr;
    assign out_bd    = mainEntry.bd;
    assign out_data  = mainEntry.data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomised checks of pipe_stage_reg in
// three configurations sharing one input bus: A (SKID=1, KEEP_PC=1),
// B (SKID=1, KEEP_PC=0), C (SKID=0, KEEP_PC=1). The reference model is a
// queue of items held by the stage plus the last value shown on the outputs.
module tb_pipe_stage_reg;

    localparam int DW = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bd;
        logic [DW-1:0] data;
    } item_t;

    // ---------------- clock / reset / stimulus signals ----------------
    logic clk;
    logic reset;
    logic flush;
    logic inValid;
    logic [31:0] inPc;
    logic [31:0] inInstr;
    logic inBd;
    logic [DW-1:0] inData;
    logic outReady;

    logic [2:0] inReadyV;
    logic [2:0] outValidV;
    logic [2:0][31:0] outPcV;
    logic [2:0][31:0] outInstrV;
    logic [2:0] outBdV;
    logic [2:0][DW-1:0] outDataV;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .SKID(1), .KEEP_PC(1)) dutA (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReadyV[0]),
        .in_pc(inPc), .in_instr(inInstr), .in_bd(inBd), .in_data(inData),
        .out_valid(outValidV[0]), .out_ready(outReady),
        .out_pc(outPcV[0]), .out_instr(outInstrV[0]), .out_bd(outBdV[0]), .out_data(outDataV[0])
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID(1), .KEEP_PC(0)) dutB (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReadyV[1]),
        .in_pc(inPc), .in_instr(inInstr), .in_bd(inBd), .in_data(inData),
        .out_valid(outValidV[1]), .out_ready(outReady),
        .out_pc(outPcV[1]), .out_instr(outInstrV[1]), .out_bd(outBdV[1]), .out_data(outDataV[1])
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID(0), .KEEP_PC(1)) dutC (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReadyV[2]),
        .in_pc(inPc), .in_instr(inInstr), .in_bd(inBd), .in_data(inData),
        .out_valid(outValidV[2]), .out_ready(outReady),
        .out_pc(outPcV[2]), .out_instr(outInstrV[2]), .out_bd(outBdV[2]), .out_data(outDataV[2])
    );

    // ---------------- counters ----------------
    int checks = 0;
    int passed = 0;

    // ---------------- reference model ----------------
    item_t mq[$];          // items currently held by the stage, oldest first
    item_t mShown;         // what the out_* data ports should show
    logic  mRdyReg;        // registered ready for the skid configurations
    int    mSkid;
    int    mKeep;
    int    sel;

    function automatic logic expReady();
        if (mSkid != 0) return mRdyReg;
        return (mq.size() == 0) || outReady;
    endfunction

    function automatic item_t obsItem(input int i);
        return {outPcV[i], outInstrV[i], outBdV[i], outDataV[i]};
    endfunction

    task automatic setCfg(input int s);
        sel   = s;
        mSkid = (s == 2) ? 0 : 1;
        mKeep = (s == 1) ? 0 : 1;
    endtask

    // One clock: advance the model with the inputs present at the edge,
    // then let the edge happen and step 1 time unit past it.
    task automatic tick();
        logic rdyNow;
        item_t it;
        rdyNow = expReady();
        it = {inPc, inInstr, inBd, inData};
        if (reset) begin
            mq.delete();
            mShown = '0;
            mRdyReg = 1'b1;
        end else if (flush) begin
            mq.delete();
            mShown.instr = '0;
            mShown.data = '0;
            if (mKeep != 0) begin
                if (inValid) begin
                    mShown.pc = inPc;
                    mShown.bd = inBd;
                end
            end else begin
                mShown.pc = '0;
                mShown.bd = 1'b0;
            end
            mRdyReg = 1'b1;
        end else begin
            if (mq.size() > 0 && outReady) void'(mq.pop_front());
            if (inValid && rdyNow) mq.push_back(it);
            if (mq.size() > 0) mShown = mq[0];
            mRdyReg = (mq.size() < 2);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] pc, input logic bd);
        inValid = v;
        inPc = pc;
        inBd = bd;
        inInstr = $urandom() | 32'h1;
        inData = {$urandom(), $urandom()};
    endtask

    task automatic doReset();
        reset = 1'b1;
        flush = 1'b0;
        inValid = 1'b0;
        outReady = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        setCfg(0);
        reset = 1'b1;
        flush = 1'b0;
        outReady = 1'b1;
        drive(1'b1, 32'h0000_1234, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        inValid = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (outValidV[i] !== 1'b0) $display("FAIL reset_valid dut=%0d got=%b exp=0", i, outValidV[i]); else passed++;
            checks++; if (outPcV[i] !== 32'h0) $display("FAIL reset_pc dut=%0d got=%h exp=0", i, outPcV[i]); else passed++;
            checks++; if (outInstrV[i] !== 32'h0) $display("FAIL reset_instr dut=%0d got=%h exp=0", i, outInstrV[i]); else passed++;
            checks++; if (outBdV[i] !== 1'b0) $display("FAIL reset_bd dut=%0d got=%b exp=0", i, outBdV[i]); else passed++;
            checks++; if (outDataV[i] !== '0) $display("FAIL reset_data dut=%0d got=%h exp=0", i, outDataV[i]); else passed++;
            checks++; if (inReadyV[i] !== 1'b1) $display("FAIL reset_ready dut=%0d got=%b exp=1", i, inReadyV[i]); else passed++;
        end
    endtask

    task automatic test_stream();
        logic [31:0] expPc;
        for (int s = 0; s < 3; s += 2) begin
            setCfg(s);
            doReset();
            outReady = 1'b1;
            for (int k = 0; k < 3; k++) begin
                expPc = 32'h3000 + 32'(4 * k);
                drive(1'b1, expPc, 1'b0);
                #1;
                checks++; if (inReadyV[s] !== 1'b1) $display("FAIL stream_ready dut=%0d k=%0d got=%b exp=1", s, k, inReadyV[s]); else passed++;
                tick();
                checks++; if (outValidV[s] !== 1'b1) $display("FAIL stream_valid dut=%0d k=%0d got=%b exp=1", s, k, outValidV[s]); else passed++;
                checks++; if (outPcV[s] !== expPc) $display("FAIL stream_pc dut=%0d k=%0d got=%h exp=%h", s, k, outPcV[s], expPc); else passed++;
            end
            inValid = 1'b0;
            tick();
            checks++; if (outValidV[s] !== 1'b0) $display("FAIL stream_end_valid dut=%0d got=%b exp=0", s, outValidV[s]); else passed++;
            checks++; if (outPcV[s] !== 32'h3008) $display("FAIL stream_end_pc dut=%0d got=%h exp=3008", s, outPcV[s]); else passed++;
        end
    endtask

    task automatic test_backpressure();
        setCfg(0);
        doReset();
        outReady = 1'b0;
        drive(1'b1, 32'h3000, 1'b0);
        #1;
        checks++; if (inReadyV[0] !== 1'b1) $display("FAIL bp_ready0 got=%b exp=1", inReadyV[0]); else passed++;
        tick();
        checks++; if (outPcV[0] !== 32'h3000 || outValidV[0] !== 1'b1) $display("FAIL bp_a_held got=%h/%b exp=3000/1", outPcV[0], outValidV[0]); else passed++;
        drive(1'b1, 32'h3004, 1'b0);
        tick();
        checks++; if (outPcV[0] !== 32'h3000) $display("FAIL bp_a_still got=%h exp=3000", outPcV[0]); else passed++;
        checks++; if (inReadyV[0] !== 1'b0) $display("FAIL bp_full_ready got=%b exp=0", inReadyV[0]); else passed++;
        drive(1'b1, 32'h3008, 1'b0);
        tick();
        checks++; if (outPcV[0] !== 32'h3000) $display("FAIL bp_a_still2 got=%h exp=3000", outPcV[0]); else passed++;
        checks++; if (inReadyV[0] !== 1'b0) $display("FAIL bp_full_ready2 got=%b exp=0", inReadyV[0]); else passed++;
        inValid = 1'b0;
        outReady = 1'b1;
        tick();
        checks++; if (outPcV[0] !== 32'h3004 || outValidV[0] !== 1'b1) $display("FAIL bp_b_out got=%h/%b exp=3004/1", outPcV[0], outValidV[0]); else passed++;
        checks++; if (inReadyV[0] !== 1'b1) $display("FAIL bp_drain_ready got=%b exp=1", inReadyV[0]); else passed++;
        tick();
        checks++; if (outValidV[0] !== 1'b0) $display("FAIL bp_empty got=%b exp=0", outValidV[0]); else passed++;
        tick();
        checks++; if (outValidV[0] !== 1'b0 || outPcV[0] !== 32'h3004) $display("FAIL bp_no_c got=%h/%b exp=3004/0", outPcV[0], outValidV[0]); else passed++;
    endtask

    task automatic test_flush_full();
        setCfg(0);
        doReset();
        outReady = 1'b0;
        drive(1'b1, 32'h3000, 1'b0);
        tick();
        drive(1'b1, 32'h3004, 1'b0);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h4180, 1'b1);
        tick();
        flush = 1'b0;
        inValid = 1'b0;
        #1;
        checks++; if (outValidV[0] !== 1'b0) $display("FAIL flush_valid got=%b exp=0", outValidV[0]); else passed++;
        checks++; if (outInstrV[0] !== 32'h0) $display("FAIL flush_instr got=%h exp=0", outInstrV[0]); else passed++;
        checks++; if (outDataV[0] !== '0) $display("FAIL flush_data got=%h exp=0", outDataV[0]); else passed++;
        checks++; if (outPcV[0] !== 32'h4180) $display("FAIL flush_keep_pc got=%h exp=4180", outPcV[0]); else passed++;
        checks++; if (outBdV[0] !== 1'b1) $display("FAIL flush_keep_bd got=%b exp=1", outBdV[0]); else passed++;
        checks++; if (inReadyV[0] !== 1'b1) $display("FAIL flush_ready got=%b exp=1", inReadyV[0]); else passed++;
        outReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (outValidV[0] !== 1'b0 || outPcV[0] !== 32'h4180) $display("FAIL flush_no_revive k=%0d got=%h/%b exp=4180/0", k, outPcV[0], outValidV[0]); else passed++;
        end
        outReady = 1'b0;
        drive(1'b1, 32'h5000, 1'b0);
        tick();
        checks++; if (outPcV[0] !== 32'h5000 || outValidV[0] !== 1'b1) $display("FAIL flush_d_held got=%h/%b exp=5000/1", outPcV[0], outValidV[0]); else passed++;
        flush = 1'b1;
        drive(1'b0, 32'h6000, 1'b1);
        tick();
        flush = 1'b0;
        #1;
        checks++; if (outPcV[0] !== 32'h5000) $display("FAIL flush_novalid_pc got=%h exp=5000", outPcV[0]); else passed++;
        checks++; if (outValidV[0] !== 1'b0 || outInstrV[0] !== 32'h0) $display("FAIL flush_novalid_bubble got=%h/%b exp=0/0", outInstrV[0], outValidV[0]); else passed++;
    endtask

    task automatic test_flush_keep0();
        setCfg(1);
        doReset();
        outReady = 1'b0;
        drive(1'b1, 32'h3000, 1'b1);
        tick();
        drive(1'b1, 32'h3004, 1'b1);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h4180, 1'b1);
        tick();
        flush = 1'b0;
        inValid = 1'b0;
        #1;
        checks++; if (outPcV[1] !== 32'h0) $display("FAIL keep0_pc got=%h exp=0", outPcV[1]); else passed++;
        checks++; if (outBdV[1] !== 1'b0) $display("FAIL keep0_bd got=%b exp=0", outBdV[1]); else passed++;
        checks++; if (outValidV[1] !== 1'b0) $display("FAIL keep0_valid got=%b exp=0", outValidV[1]); else passed++;
        checks++; if (outInstrV[1] !== 32'h0 || outDataV[1] !== '0) $display("FAIL keep0_fields got=%h/%h exp=0/0", outInstrV[1], outDataV[1]); else passed++;
        checks++; if (inReadyV[1] !== 1'b1) $display("FAIL keep0_ready got=%b exp=1", inReadyV[1]); else passed++;
    endtask

    task automatic test_reset_vs_flush();
        setCfg(0);
        doReset();
        outReady = 1'b0;
        drive(1'b1, 32'h3000, 1'b1);
        tick();
        reset = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'h3010, 1'b1);
        tick();
        reset = 1'b0;
        flush = 1'b0;
        inValid = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (outPcV[i] !== 32'h0 || outBdV[i] !== 1'b0) $display("FAIL rvf_pc dut=%0d got=%h/%b exp=0/0", i, outPcV[i], outBdV[i]); else passed++;
            checks++; if (outValidV[i] !== 1'b0 || outInstrV[i] !== 32'h0 || outDataV[i] !== '0) $display("FAIL rvf_fields dut=%0d got=%b/%h/%h exp=0/0/0", i, outValidV[i], outInstrV[i], outDataV[i]); else passed++;
        end
    endtask

    task automatic test_skid0_ready();
        logic pat [3];
        pat[0] = 1'b1;
        pat[1] = 1'b0;
        pat[2] = 1'b1;
        setCfg(2);
        doReset();
        outReady = 1'b0;
        drive(1'b1, 32'h7000, 1'b0);
        tick();
        inValid = 1'b0;
        #1;
        checks++; if (outValidV[2] !== 1'b1 || outPcV[2] !== 32'h7000) $display("FAIL s0_loaded got=%h/%b exp=7000/1", outPcV[2], outValidV[2]); else passed++;
        for (int k = 0; k < 3; k++) begin
            outReady = pat[k];
            #1;
            checks++; if (inReadyV[2] !== pat[k]) $display("FAIL s0_comb_ready k=%0d got=%b exp=%b", k, inReadyV[2], pat[k]); else passed++;
        end
        tick();
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            setCfg(s);
            doReset();
            for (int cyc = 0; cyc < 1000; cyc++) begin
                reset = ($urandom_range(0, 199) == 0);
                flush = ($urandom_range(0, 39) == 0);
                outReady = ($urandom_range(0, 9) < 6);
                drive($urandom_range(0, 9) < 7, $urandom(), 1'($urandom_range(0, 1)));
                #1;
                checks++; if (outValidV[s] !== (mq.size() > 0)) $display("FAIL rnd_valid dut=%0d cyc=%0d got=%b exp=%b", s, cyc, outValidV[s], mq.size() > 0); else passed++;
                checks++; if (inReadyV[s] !== expReady()) $display("FAIL rnd_ready dut=%0d cyc=%0d got=%b exp=%b", s, cyc, inReadyV[s], expReady()); else passed++;
                checks++; if (obsItem(s) !== mShown) $display("FAIL rnd_item dut=%0d cyc=%0d got=%h exp=%h", s, cyc, obsItem(s), mShown); else passed++;
                tick();
            end
            reset = 1'b0;
            flush = 1'b0;
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        reset = 1'b1;
        flush = 1'b0;
        inValid = 1'b0;
        inPc = '0;
        inInstr = '0;
        inBd = 1'b0;
        inData = '0;
        outReady = 1'b0;
        mShown = '0;
        mRdyReg = 1'b1;
        setCfg(0);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_flush_keep0();
        test_reset_vs_flush();
        test_skid0_ready();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
